dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared data memory. Port 0 (CPU load/store stage) and port 1 (DMA/debug loader) issue read or write requests. The block grants one request at a time using round-robin order, drives the memory control signals (MemRead, MemWrite, address, write data, opcode) for a fixed access window, and returns read data and a completion pulse to the granted requester. Out-of-range addresses complete with an error flag and never reach memory.

---
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the
// shared data memory.
interface dmem_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [5:0]  opc0, opc1;
    logic        gnt0, gnt1;
    logic        done0, done1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [5:0]  mem_opcode;
    logic        mem_MemRead, mem_MemWrite;
    logic [31:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, opc0, opc1,
        input  mem_read_data,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
        output mem_address, mem_write_data, mem_opcode, mem_MemRead, mem_MemWrite
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, opc0, opc1,
        output mem_read_data,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
        input  mem_address, mem_write_data, mem_opcode, mem_MemRead, mem_MemWrite
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the shared data memory: latches one request,
// holds the memory strobes for MEM_LAT cycles, then pulses done to its owner.
module dmem_arbiter #(
    parameter int MEM_LAT   = 1,
    parameter int MEM_DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0]  CNT_INIT = 4'(MEM_LAT - 1);
    localparam logic [31:0] DEPTH    = 32'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic        sel_q, last_q, we_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [5:0]  opc_q;
    logic [3:0]  cnt_q;
    logic [1:0]  gnt_q;

    logic        any_req, win, win_we, win_err;
    logic [31:0] win_addr, win_wdata;
    logic [5:0]  win_opc;

    // On a tie the port that was not served last wins.
    always_comb begin
        any_req   = bus.req0 | bus.req1;
        win       = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
        win_we    = win ? bus.we1    : bus.we0;
        win_addr  = win ? bus.addr1  : bus.addr0;
        win_wdata = win ? bus.wdata1 : bus.wdata0;
        win_opc   = win ? bus.opc1   : bus.opc0;
        win_err   = (win_addr >= DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.gnt0           = gnt_q[0];
        bus.gnt1           = gnt_q[1];
        bus.done0          = 1'b0;
        bus.done1          = 1'b0;
        bus.err0           = 1'b0;
        bus.err1           = 1'b0;
        bus.rdata0         = '0;
        bus.rdata1         = '0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.mem_opcode     = '0;
        bus.mem_MemRead    = 1'b0;
        bus.mem_MemWrite   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = win_err ? DONE : ACCESS;
            end
            ACCESS: begin
                bus.mem_address    = addr_q;
                bus.mem_write_data = wdata_q;
                bus.mem_opcode     = opc_q;
                bus.mem_MemRead    = ~we_q;
                bus.mem_MemWrite   = we_q;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                // Read data only for a successful read; errors and writes show 0.
                if (sel_q) begin
                    bus.done1  = 1'b1;
                    bus.err1   = err_q;
                    bus.rdata1 = (!we_q && !err_q) ? rdata_q : '0;
                end else begin
                    bus.done0  = 1'b1;
                    bus.err0   = err_q;
                    bus.rdata0 = (!we_q && !err_q) ? rdata_q : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            opc_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            gnt_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q   <= win;
                        we_q    <= win_we;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        opc_q   <= win_opc;
                        err_q   <= win_err;
                        cnt_q   <= CNT_INIT;
                        gnt_q   <= win ? 2'b10 : 2'b01;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == '0 && !we_q) rdata_q <= bus.mem_read_data;
                end
                DONE: begin
                    last_q <= sel_q;
                    err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiters with MEM_LAT 1, 3 and 4 share clock and reset.
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    dmem_arbiter_if i1 ();
    dmem_arbiter_if i3 ();
    dmem_arbiter_if i4 ();

    dmem_arbiter #(.MEM_LAT(1), .MEM_DEPTH(256)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    dmem_arbiter #(.MEM_LAT(3), .MEM_DEPTH(256)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));
    dmem_arbiter #(.MEM_LAT(4), .MEM_DEPTH(256)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire any1 = i1.gnt0 | i1.gnt1 | i1.done0 | i1.done1 | i1.err0 | i1.err1 | (|i1.rdata0) |
                (|i1.rdata1) | (|i1.mem_address) | (|i1.mem_write_data) | (|i1.mem_opcode) |
                i1.mem_MemRead | i1.mem_MemWrite;
    wire any3 = i3.gnt0 | i3.gnt1 | i3.done0 | i3.done1 | i3.err0 | i3.err1 | (|i3.rdata0) |
                (|i3.rdata1) | (|i3.mem_address) | (|i3.mem_write_data) | (|i3.mem_opcode) |
                i3.mem_MemRead | i3.mem_MemWrite;
    wire any4 = i4.gnt0 | i4.gnt1 | i4.done0 | i4.done1 | i4.err0 | i4.err1 | (|i4.rdata0) |
                (|i4.rdata1) | (|i4.mem_address) | (|i4.mem_write_data) | (|i4.mem_opcode) |
                i4.mem_MemRead | i4.mem_MemWrite;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic p;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;

        // Reset with random inputs on every port
        for (int r = 0; r < 2; r++) begin
            {i1.req0, i1.req1, i1.we0, i1.we1} = 4'($urandom);
            {i3.req0, i3.req1, i3.we0, i3.we1} = 4'($urandom);
            {i4.req0, i4.req1, i4.we0, i4.we1} = 4'($urandom);
            i1.addr0 = $urandom; i1.addr1 = $urandom; i1.wdata0 = $urandom; i1.wdata1 = $urandom;
            i3.addr0 = $urandom; i3.addr1 = $urandom; i3.wdata0 = $urandom; i3.wdata1 = $urandom;
            i4.addr0 = $urandom; i4.addr1 = $urandom; i4.wdata0 = $urandom; i4.wdata1 = $urandom;
            i1.opc0 = 6'($urandom); i1.opc1 = 6'($urandom); i1.mem_read_data = $urandom;
            i3.opc0 = 6'($urandom); i3.opc1 = 6'($urandom); i3.mem_read_data = $urandom;
            i4.opc0 = 6'($urandom); i4.opc1 = 6'($urandom); i4.mem_read_data = $urandom;
            tick();
            chk("rst_hold_u1", any1, 0);
            chk("rst_hold_u3", any3, 0);
            chk("rst_hold_u4", any4, 0);
        end
        i1.req0 = 0; i1.req1 = 0; i3.req0 = 0; i3.req1 = 0; i4.req0 = 0; i4.req1 = 0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_u1", any1, 0);
        chk("post_rst_u3", any3, 0);
        chk("post_rst_u4", any4, 0);

        // Single read, MEM_LAT=1
        i1.req0 = 1; i1.we0 = 0; i1.addr0 = 32'd5; i1.mem_read_data = 32'hDEADBEEF;
        tick();
        chk("rd_gnt0", i1.gnt0, 1);
        chk("rd_memread", i1.mem_MemRead, 1);
        chk("rd_memwrite", i1.mem_MemWrite, 0);
        chk("rd_addr", i1.mem_address, 32'd5);
        chk("rd_done_early", i1.done0, 0);
        i1.req0 = 0;
        tick();
        chk("rd_gnt0_drop", i1.gnt0, 0);
        chk("rd_memread_drop", i1.mem_MemRead, 0);
        chk("rd_done0", i1.done0, 1);
        chk("rd_rdata0", i1.rdata0, 32'hDEADBEEF);
        chk("rd_err0", i1.err0, 0);
        tick();
        chk("rd_done0_pulse", i1.done0, 0);
        chk("rd_rdata0_clr", i1.rdata0, 0);

        // Write, MEM_LAT=3
        i3.req1 = 1; i3.we1 = 1; i3.addr1 = 32'd10; i3.wdata1 = 32'h12345678; i3.opc1 = 6'h28;
        tick();
        chk("wr_gnt1", i3.gnt1, 1);
        i3.req1 = 0;
        for (int c = 0; c < 3; c++) begin
            chk("wr_memwrite", i3.mem_MemWrite, 1);
            chk("wr_memread", i3.mem_MemRead, 0);
            chk("wr_data", i3.mem_write_data, 32'h12345678);
            chk("wr_opc", i3.mem_opcode, 6'h28);
            chk("wr_addr", i3.mem_address, 32'd10);
            chk("wr_done_early", i3.done1, 0);
            tick();
        end
        chk("wr_memwrite_drop", i3.mem_MemWrite, 0);
        chk("wr_done1", i3.done1, 1);
        chk("wr_rdata1", i3.rdata1, 0);
        chk("wr_err1", i3.err1, 0);
        tick();
        chk("wr_done1_pulse", i3.done1, 0);

        // Contention after reset, MEM_LAT=4: grant order 0,1,0,1
        i4.req0 = 1; i4.req1 = 1; i4.we0 = 0; i4.we1 = 0;
        i4.addr0 = 32'd3; i4.addr1 = 32'd4; i4.mem_read_data = 32'hCAFE0004;
        for (int k = 0; k < 4; k++) begin
            p = k[0];
            tick();
            chk("cont_gnt0", i4.gnt0, 32'(!p));
            chk("cont_gnt1", i4.gnt1, 32'(p));
            chk("cont_addr", i4.mem_address, p ? 32'd4 : 32'd3);
            repeat (3) tick();
            chk("cont_strobe_last", i4.mem_MemRead, 1);
            tick();
            chk("cont_done0", i4.done0, 32'(!p));
            chk("cont_done1", i4.done1, 32'(p));
            chk("cont_rdata0", i4.rdata0, p ? 32'd0 : 32'hCAFE0004);
            chk("cont_rdata1", i4.rdata1, p ? 32'hCAFE0004 : 32'd0);
            tick();
            chk("cont_idle", any4, 0);
        end
        i4.req0 = 0; i4.req1 = 0;

        // Out-of-range address: done/err with no strobes
        i1.req0 = 1; i1.we0 = 0; i1.addr0 = 32'd256;
        tick();
        chk("err_gnt0", i1.gnt0, 1);
        chk("err_done0", i1.done0, 1);
        chk("err_err0", i1.err0, 1);
        chk("err_strobes", {i1.mem_MemRead, i1.mem_MemWrite}, 0);
        chk("err_rdata0", i1.rdata0, 0);
        i1.req0 = 0;
        tick();
        chk("err_clear", any1, 0);

        // Full 32-bit compare: top-bit address is out of range
        i1.req1 = 1; i1.we1 = 1; i1.addr1 = 32'h8000_0005;
        tick();
        chk("err_hi_err1", i1.err1, 1);
        chk("err_hi_strobe", i1.mem_MemWrite, 0);
        i1.req1 = 0;
        tick();

        // Last legal address is accepted
        i1.req0 = 1; i1.we0 = 0; i1.addr0 = 32'd255;
        tick();
        chk("edge_strobe", i1.mem_MemRead, 1);
        chk("edge_addr", i1.mem_address, 32'd255);
        i1.req0 = 0;
        tick();
        chk("edge_done0", i1.done0, 1);
        chk("edge_err0", i1.err0, 0);
        tick();

        // Reset during the 2nd ACCESS cycle of a port-1 write
        i4.req1 = 1; i4.we1 = 1; i4.addr1 = 32'd7; i4.wdata1 = 32'h0000_0055;
        tick();
        chk("mid_gnt1", i4.gnt1, 1);
        chk("mid_strobe1", i4.mem_MemWrite, 1);
        i4.req1 = 0;
        tick();
        chk("mid_strobe2", i4.mem_MemWrite, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_strobe_drop", i4.mem_MemWrite, 0);
        chk("mid_all_zero", any4, 0);
        tick();
        chk("mid_no_done1", i4.done1, 0);
        i4.req0 = 1; i4.req1 = 1; i4.we0 = 0; i4.we1 = 0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("mid_rel_gnt0", i4.gnt0, 1);
        chk("mid_rel_gnt1", i4.gnt1, 0);
        chk("mid_rel_done1", i4.done1, 0);
        i4.req0 = 0; i4.req1 = 0;
        repeat (3) tick();
        chk("mid_rel_no_done", i4.done0, 0);
        tick();
        chk("mid_rel_done0", i4.done0, 1);
        chk("mid_rel_rdata0", i4.rdata0, 32'hCAFE0004);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
